// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction from memory, holds it
// until the downstream stage consumes it, then redirects the PC to the selected target.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst,
  output logic [5:0]         opcode,
  output logic [5:0]         funccode,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               pcsrc,
  input  logic               adrtopc,
  input  logic               regtopc,
  input  logic [31:0]        reg_data,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [COUNT_W-1:0] inst_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                started;
  logic [31:0]         pc_r;
  logic [31:0]         inst_r;
  logic [COUNT_W-1:0]  count_r;
  logic [31:0]         next_pc;
  logic                capture;
  logic                consume;

  // Low address bits of a register target are dropped on purpose.
  logic unused_reg_bits;
  assign unused_reg_bits = &{1'b0, reg_data[1:0]};

  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                               input logic [25:0] index);
    return {pc4_hi, index, 2'b00};
  endfunction

  function automatic logic [31:0] reg_target(input logic [29:0] reg_hi);
    return {reg_hi, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                 input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return pc4 + $unsigned(offset);
  endfunction

  assign pc_plus4   = pc_r + 32'd4;
  assign pc         = pc_r;
  assign inst       = inst_r;
  assign inst_count = count_r;
  assign opcode     = inst_r[31:26];
  assign funccode   = inst_r[5:0];
  assign imem_addr  = pc_r;

  // The request only rises on the first edge after reset release, so the
  // memory never sees a request while it is still discarding in-flight reads.
  assign imem_req   = started && (state == FETCH);
  assign inst_valid = (state == HOLD);
  assign capture    = imem_req && imem_ack;
  assign consume    = (state == HOLD) && inst_ready;

  always_comb begin
    next_pc = pc_plus4;
    if (adrtopc)
      next_pc = jump_target(pc_plus4[31:28], inst_r[25:0]);
    else if (regtopc)
      next_pc = reg_target(reg_data[31:2]);
    else if (pcsrc)
      next_pc = branch_target(pc_plus4, inst_r[15:0]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (capture) state_nxt = HOLD;
      HOLD:    if (inst_ready) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      started <= 1'b0;
      pc_r    <= RESET_PC;
      inst_r  <= 32'h0;
      count_r <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (capture)
        inst_r <= imem_rdata;
      if (consume) begin
        pc_r    <= next_pc;
        count_r <= count_r + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level PC/count model.
module tb_instruction_fetch_unit;

  localparam int          CW  = 8;
  localparam logic [31:0] RPC = 32'h00000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   inst;
  logic [5:0]    opcode;
  logic [5:0]    funccode;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic          pcsrc = 1'b0;
  logic          adrtopc = 1'b0;
  logic          regtopc = 1'b0;
  logic [31:0]   reg_data = 32'h0;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [CW-1:0] inst_count;

  int checks = 0;
  int errors = 0;

  logic [31:0]   m_pc;
  logic [31:0]   m_inst;
  logic [CW-1:0] m_count;

  instruction_fetch_unit #(.RESET_PC(RPC), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .opcode(opcode), .funccode(funccode), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pcsrc(pcsrc), .adrtopc(adrtopc), .regtopc(regtopc),
    .reg_data(reg_data), .pc(pc), .pc_plus4(pc_plus4), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input bit br, input bit ad, input bit rg,
                                           input logic [31:0] rd);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(word[15:0])) * 4;
    if (ad)      return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    else if (rg) return rd & 32'hFFFF_FFFC;
    else if (br) return seq + 32'(off);
    else         return seq;
  endfunction

  task automatic fetch_one(input logic [31:0] data, input int waits);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req: imem_req=%b required 1", imem_req);
    end
    for (int i = 0; i < waits; i++) begin
      checks++;
      if (imem_addr !== m_pc || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL fetch_wait: addr=%h valid=%b req=%b required addr=%h valid=0 req=1",
                 imem_addr, inst_valid, imem_req, m_pc);
      end
      @(negedge clk);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    m_inst = data;
    checks++;
    if (inst_valid !== 1'b1 || inst !== m_inst || pc !== m_pc || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_load: valid=%b inst=%h pc=%h req=%b required 1 %h %h 0",
               inst_valid, inst, pc, imem_req, m_inst, m_pc);
    end
    checks++;
    if (opcode !== m_inst[31:26] || funccode !== m_inst[5:0]) begin
      errors++;
      $display("FAIL decode: opcode=%h funccode=%h required %h %h",
               opcode, funccode, m_inst[31:26], m_inst[5:0]);
    end
  endtask

  task automatic consume_one(input bit br, input bit ad, input bit rg, input logic [31:0] rd);
    checks++;
    if (pc_plus4 !== m_pc + 32'd4) begin
      errors++;
      $display("FAIL pc_plus4: got %h required %h", pc_plus4, m_pc + 32'd4);
    end
    pcsrc = br; adrtopc = ad; regtopc = rg; reg_data = rd;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    pcsrc = 1'($urandom); adrtopc = 1'($urandom); regtopc = 1'($urandom); reg_data = $urandom;
    m_pc = ref_next(m_pc, m_inst, br, ad, rg, rd);
    m_count++;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || inst_valid !== 1'b0 ||
        inst_count !== m_count) begin
      errors++;
      $display("FAIL consume: req=%b addr=%h pc=%h valid=%b count=%0d required 1 %h %h 0 %0d",
               imem_req, imem_addr, pc, inst_valid, inst_count, m_pc, m_pc, m_count);
    end
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      pcsrc = 1'($urandom); adrtopc = 1'($urandom); regtopc = 1'($urandom); reg_data = $urandom;
      @(negedge clk);
      checks++;
      if (inst !== m_inst || pc !== m_pc || inst_count !== m_count || imem_req !== 1'b0 ||
          inst_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold: inst=%h pc=%h count=%0d req=%b valid=%b required %h %h %0d 0 1",
                 inst, pc, inst_count, imem_req, inst_valid, m_inst, m_pc, m_count);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #1;
    m_pc = RPC; m_inst = 32'h0; m_count = '0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== RPC || inst !== 32'h0 ||
        inst_count !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h inst=%h count=%0d required 0 0 %h 0 0",
               imem_req, inst_valid, pc, inst, inst_count, RPC);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_before_edge: imem_req=%b required 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h required 1 %h", imem_req, imem_addr, RPC);
    end
  endtask

  task automatic test_first_fetch;
    fetch_one(32'h012A4020, 3);
    checks++;
    if (opcode !== 6'h00 || funccode !== 6'h20 || inst !== 32'h012A4020) begin
      errors++;
      $display("FAIL first_fetch: opcode=%h funccode=%h inst=%h required 00 20 012a4020",
               opcode, funccode, inst);
    end
  endtask

  task automatic test_branch;
    consume_one(0, 0, 1, 32'h40);
    fetch_one(32'h1000FFFE, 1);
    consume_one(1, 0, 0, 32'h0);
    checks++;
    if (imem_addr !== 32'h3C) begin
      errors++;
      $display("FAIL branch_back: addr=%h required 0000003c", imem_addr);
    end
  endtask

  task automatic test_jump_priority;
    fetch_one($urandom, 0);
    consume_one(0, 0, 1, 32'h43);
    fetch_one(32'h0C000100, 2);
    checks++;
    if (pc_plus4 !== 32'h44) begin
      errors++;
      $display("FAIL jal_link: pc_plus4=%h required 00000044", pc_plus4);
    end
    consume_one(1, 1, 1, 32'h9999);
    checks++;
    if (pc !== 32'h400) begin
      errors++;
      $display("FAIL jump_wins: pc=%h required 00000400", pc);
    end
  endtask

  task automatic test_regtarget_and_wrap;
    fetch_one($urandom, 1);
    consume_one(1, 0, 1, 32'h00001237);
    checks++;
    if (pc !== 32'h1234) begin
      errors++;
      $display("FAIL reg_target: pc=%h required 00001234", pc);
    end
    fetch_one($urandom, 0);
    consume_one(0, 0, 1, 32'hFFFFFFFF);
    fetch_one(32'h00000000, 0);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: pc_plus4=%h required 00000000", pc_plus4);
    end
    consume_one(0, 0, 0, 32'h0);
  endtask

  task automatic test_hold_stall;
    fetch_one($urandom, 2);
    hold_cycles(5);
    consume_one(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic test_random;
    for (int n = 0; n < 280; n++) begin
      fetch_one($urandom, int'($urandom_range(0, 3)));
      hold_cycles(int'($urandom_range(0, 2)));
      consume_one(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  task automatic test_reset_mid_fetch;
    fetch_one($urandom, 0);
    consume_one(0, 0, 1, 32'h80);
    #2 rst = 1'b0;
    #1;
    m_pc = RPC; m_inst = 32'h0; m_count = '0;
    checks++;
    if (imem_req !== 1'b0 || pc !== RPC || inst_count !== '0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h count=%0d inst=%h required 0 %h 0 0",
               imem_req, pc, inst_count, inst, RPC);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || inst_count !== '0) begin
      errors++;
      $display("FAIL after_reset: req=%b addr=%h count=%0d required 1 %h 0",
               imem_req, imem_addr, inst_count, RPC);
    end
    fetch_one($urandom, 1);
    consume_one(0, 0, 0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_branch;
    test_jump_priority;
    test_regtarget_and_wrap;
    test_hold_stall;
    test_random;
    test_reset_mid_fetch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
